// File: rtl/mem_copy_loader.sv
// mem_copy_loader
// Host-side loader that sits directly upstream of the BK memory block. It turns
// the OSD/IO-controller byte stream into 16-bit mem_copy word accesses with
// timed strobes, and holds the CPU in reset while a transfer is active.
//   Physical mode: ioctl_addr is the raw SDRAM byte address.
//   Virtual mode (ioctl_index == VIRT_INDEX): a BK .bin image. Bytes 0-1 give
//   the load address A and bytes 2-3 the length L, both little-endian. Data
//   byte n lands at CPU address (A + n - 4) mod 2^16.
// Ports:
//   clk_sys, reset       clock, asynchronous active-high reset
//   ioctl_download/upload host transfer active (download has priority)
//   ioctl_index          image type, latched at transfer start
//   ioctl_wr/rd          one-cycle byte write strobe / byte read request
//   ioctl_addr           byte address / offset of the current byte
//   ioctl_dout/din       download byte / upload byte
//   ioctl_wait           host must stall; high while a word access is in flight
//   mem_copy             copy mode active (also drives cpu_reset)
//   mem_copy_virt        virtual addressing
//   mem_copy_addr        word-aligned byte address
//   mem_copy_din/dout    write data (little-endian) / read data
//   mem_copy_we/rd       write / read strobes
//   cpu_reset            hold CPU in reset
//   load_done            one-cycle pulse at the end of a download
//   overrun              sticky: a byte was lost; cleared at the next download
module mem_copy_loader #(
    parameter int         WE_CYCLES  = 8,
    parameter int         RD_CYCLES  = 8,
    parameter logic [7:0] VIRT_INDEX = 8'd1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic        mem_copy,
    output logic        mem_copy_virt,
    output logic [24:0] mem_copy_addr,
    output logic [15:0] mem_copy_din,
    input  logic [15:0] mem_copy_dout,
    output logic        mem_copy_we,
    output logic        mem_copy_rd,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, LOW, WRITE, READ, FLUSH, TAIL} state_t;

    // WRITE runs WE_CYCLES strobe cycles plus one low cycle; READ samples on its last cycle.
    localparam logic [7:0] WE_LAST = 8'(WE_CYCLES);
    localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);

    state_t      state, state_d;
    logic        active, dl_mode;
    logic [7:0]  cnt;
    logic [7:0]  lo_byte;
    logic [24:0] lo_addr;
    logic        skid_valid;
    logic [7:0]  skid_data;
    logic [24:0] skid_addr;
    logic [15:0] hdr_addr, hdr_len;
    logic        cache_valid;
    logic [23:0] cache_word;
    logic [15:0] cache_data;
    logic        rd_sel;

    // Byte decode: the skid byte always goes before a freshly arriving one.
    logic        proc_ok, up_ok, take_skid, take_in, take;
    logic [7:0]  b_data;
    logic [24:0] b_off, b_rel, b_tgt;
    logic [15:0] b_vaddr;
    logic        b_hdr, b_drop, b_hi, rd_req, cache_hit;

    assign mem_copy  = active;
    assign cpu_reset = active;

    always_comb begin
        proc_ok   = active && dl_mode && (state == IDLE || state == LOW);
        up_ok     = active && !dl_mode && (state == IDLE);
        take_skid = proc_ok && skid_valid;
        take_in   = proc_ok && !skid_valid && ioctl_wr;
        take      = take_skid || take_in;
        b_data    = take_skid ? skid_data : ioctl_dout;
        b_off     = take_skid ? skid_addr : ioctl_addr;
        b_rel     = b_off - 25'd4;
        // 16-bit add: the CPU address space wraps at 64 KiB.
        b_vaddr   = hdr_addr + b_rel[15:0];
        b_hdr     = mem_copy_virt && (b_off < 25'd4);
        b_drop    = mem_copy_virt && !b_hdr && (b_rel >= {9'd0, hdr_len});
        // Byte lane follows the target address, which differs from ioctl_addr when A is odd.
        b_tgt     = mem_copy_virt ? {9'd0, b_vaddr} : b_off;
        b_hi      = b_tgt[0];
        // A simultaneous ioctl_wr suppresses the read request.
        rd_req    = up_ok && ioctl_rd && !ioctl_wr;
        cache_hit = cache_valid && (cache_word == ioctl_addr[24:1]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d     = state;
        mem_copy_we = 1'b0;
        mem_copy_rd = 1'b0;
        ioctl_wait  = 1'b0;
        unique case (state)
            IDLE, LOW: begin
                if (proc_ok) begin
                    if (take) begin
                        if (!b_hdr && !b_drop) state_d = b_hi ? WRITE : LOW;
                    end else if (!ioctl_download) begin
                        // Download ended and the skid is empty: flush an unpaired low byte.
                        state_d = (state == LOW) ? FLUSH : TAIL;
                    end
                end else if (rd_req && !cache_hit) begin
                    state_d = READ;
                end
            end
            WRITE: begin
                mem_copy_we = (cnt < WE_LAST);
                ioctl_wait  = 1'b1;
                if (cnt == WE_LAST) state_d = IDLE;
            end
            READ: begin
                mem_copy_rd = 1'b1;
                ioctl_wait  = 1'b1;
                if (cnt == RD_LAST) state_d = IDLE;
            end
            FLUSH:   state_d = WRITE;
            TAIL:    if (cnt == 8'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            active        <= 1'b0;
            dl_mode       <= 1'b0;
            mem_copy_virt <= 1'b0;
            cnt           <= '0;
            lo_byte       <= '0;
            lo_addr       <= '0;
            skid_valid    <= 1'b0;
            skid_data     <= '0;
            skid_addr     <= '0;
            hdr_addr      <= '0;
            hdr_len       <= '0;
            cache_valid   <= 1'b0;
            cache_word    <= '0;
            cache_data    <= '0;
            rd_sel        <= 1'b0;
            mem_copy_addr <= '0;
            mem_copy_din  <= '0;
            ioctl_din     <= '0;
            load_done     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            load_done <= 1'b0;
            cnt       <= (state_d != state) ? 8'd0 : cnt + 8'd1;

            // Level-triggered start: an upload raised during a download waits for IDLE.
            if (state == IDLE && !active) begin
                if (ioctl_download) begin
                    active        <= 1'b1;
                    dl_mode       <= 1'b1;
                    mem_copy_virt <= (ioctl_index == VIRT_INDEX);
                    overrun       <= 1'b0;
                    skid_valid    <= 1'b0;
                    hdr_addr      <= '0;
                    hdr_len       <= '0;
                end else if (ioctl_upload) begin
                    active        <= 1'b1;
                    dl_mode       <= 1'b0;
                    mem_copy_virt <= (ioctl_index == VIRT_INDEX);
                    cache_valid   <= 1'b0;
                end
            end

            if (take) begin
                if (b_hdr) begin
                    unique case (b_off[1:0])
                        2'd0: hdr_addr[7:0]  <= b_data;
                        2'd1: hdr_addr[15:8] <= b_data;
                        2'd2: hdr_len[7:0]   <= b_data;
                        2'd3: hdr_len[15:8]  <= b_data;
                    endcase
                end else if (!b_drop) begin
                    if (b_hi) begin
                        mem_copy_addr <= {b_tgt[24:1], 1'b0};
                        mem_copy_din  <= {b_data, (state == LOW) ? lo_byte : 8'h00};
                        cache_valid   <= 1'b0;
                    end else begin
                        lo_byte <= b_data;
                        lo_addr <= {b_tgt[24:1], 1'b0};
                    end
                end
            end

            // Skid: a byte that cannot be taken directly is parked in one slot; a
            // byte arriving while the slot stays occupied is lost.
            if (take_skid) skid_valid <= 1'b0;
            if (ioctl_wr && ioctl_download && active && dl_mode && !take_in) begin
                if (!skid_valid || take_skid) begin
                    skid_valid <= 1'b1;
                    skid_data  <= ioctl_dout;
                    skid_addr  <= ioctl_addr;
                end else begin
                    overrun <= 1'b1;
                end
            end

            if (state == FLUSH) begin
                mem_copy_addr <= lo_addr;
                mem_copy_din  <= {8'h00, lo_byte};
                cache_valid   <= 1'b0;
            end

            if (state == IDLE && state_d == READ) begin
                mem_copy_addr <= {ioctl_addr[24:1], 1'b0};
                rd_sel        <= ioctl_addr[0];
            end
            if (state == READ && cnt == RD_LAST) begin
                cache_valid <= 1'b1;
                cache_word  <= mem_copy_addr[24:1];
                cache_data  <= mem_copy_dout;
                ioctl_din   <= rd_sel ? mem_copy_dout[15:8] : mem_copy_dout[7:0];
            end
            if (rd_req && cache_hit) begin
                ioctl_din <= ioctl_addr[0] ? cache_data[15:8] : cache_data[7:0];
            end

            if (state == TAIL && state_d == IDLE) begin
                load_done <= 1'b1;
                active    <= 1'b0;
            end
            if (up_ok && !ioctl_upload) active <= 1'b0;
        end
    end

endmodule
